// File: rtl/if_id_fetch_queue.sv
// ============================================================================
// Module   : if_id_fetch_queue
// Brief    : IF->ID instruction queue (circular buffer, valid/ready on both
//            sides, flush for branch redirects). Optional macro
//            IFID_BUBBLE_NOP_EN presents an ADDI x0,x0,0 bubble when empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_fetch_queue #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     if_valid,
    output logic                     if_ready,
    input  logic [XLEN-1:0]          if_pc,
    input  logic [XLEN-1:0]          if_pc_plus4,
    input  logic [31:0]              if_instruction,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [XLEN-1:0]          id_pc,
    output logic [XLEN-1:0]          id_pc_plus4,
    output logic [31:0]              id_instruction,
    output logic [$clog2(DEPTH):0]   id_count
);

    localparam int                c_AW    = $clog2(DEPTH);
    localparam int                c_EW    = 2 * XLEN + 32;
    localparam logic [c_AW:0]     c_FULL  = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]     c_CNT1  = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0]   c_PTR1  = c_AW'(1);

    // Entry layout: {pc, pc_plus4, instruction}
    logic [c_EW-1:0]  r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic [c_AW:0]    w_count_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_if_ready;
    logic             w_id_valid;
    logic [c_EW-1:0]  w_wr_entry;
    logic [c_EW-1:0]  w_head;

    // Handshakes depend only on registered occupancy: no ready bypass
    assign w_if_ready = (r_count != c_FULL);
    assign w_id_valid = (r_count != '0);
    assign w_push     = if_valid && w_if_ready && !flush;
    assign w_pop      = w_id_valid && id_ready && !flush;
    assign w_wr_entry = {if_pc, if_pc_plus4, if_instruction};
    assign w_head     = r_mem[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNT1;
            2'b01:   w_count_nxt = r_count - c_CNT1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            // Storage is left as-is; only the bookkeeping is cleared
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_wr_entry;
                r_wr_ptr        <= r_wr_ptr + c_PTR1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR1;
            end
            r_count <= w_count_nxt;
        end
    end

    assign if_ready = w_if_ready;
    assign id_valid = w_id_valid;
    assign id_count = r_count;

`ifdef IFID_BUBBLE_NOP_EN
    assign id_pc          = w_id_valid ? w_head[c_EW-1 -: XLEN]   : '0;
    assign id_pc_plus4    = w_id_valid ? w_head[32 +: XLEN]        : '0;
    assign id_instruction = w_id_valid ? w_head[31:0]              : 32'h0000_0013;
`else
    assign id_pc          = w_head[c_EW-1 -: XLEN];
    assign id_pc_plus4    = w_head[32 +: XLEN];
    assign id_instruction = w_head[31:0];
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_fetch_queue.sv
// ============================================================================
// Module   : tb_if_id_fetch_queue
// Brief    : Self-checking bench for if_id_fetch_queue with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_fetch_queue;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;
`ifdef IFID_BUBBLE_NOP_EN
    localparam logic [31:0] c_EMPTY_INS = 32'h0000_0013;
`else
    localparam logic [31:0] c_EMPTY_INS = 32'h0000_0000;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic                   if_valid;
    logic                   if_ready;
    logic [XLEN-1:0]        if_pc;
    logic [XLEN-1:0]        if_pc_plus4;
    logic [31:0]            if_instruction;
    logic                   id_valid;
    logic                   id_ready;
    logic [XLEN-1:0]        id_pc;
    logic [XLEN-1:0]        id_pc_plus4;
    logic [31:0]            id_instruction;
    logic [$clog2(DEPTH):0] id_count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] ins;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;

    if_id_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .if_instruction (if_instruction),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_instruction (id_instruction),
        .id_count       (id_count)
    );

    always #5 clk = ~clk;

    // Present an instruction whose payload is derived from its pc
    task automatic present(input logic [31:0] pc);
        if_valid       = 1'b1;
        if_pc          = pc;
        if_pc_plus4    = pc + 32'd4;
        if_instruction = pc ^ 32'h0050_0093;
    endtask

    // One clock: the model applies the queue rules to the inputs seen at the edge
    task automatic tick();
        bit   push;
        bit   pop;
        ent_t e;
        push = if_valid && (q.size() < DEPTH) && !flush && !rst;
        pop  = (q.size() > 0) && id_ready && !flush && !rst;
        e    = '{pc: if_pc, pc4: if_pc_plus4, ins: if_instruction};
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(e);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        if_pc = '0; if_pc_plus4 = '0; if_instruction = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++;
        if (if_ready !== 1'b1 || id_valid !== 1'b0 || id_count !== 0) begin
            errors++;
            $display("FAIL reset_flags: if_ready=%b id_valid=%b id_count=%0d, want 1 0 0",
                     if_ready, id_valid, id_count);
        end
        checks++;
        if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h0 || id_instruction !== c_EMPTY_INS) begin
            errors++;
            $display("FAIL reset_payload: pc=%h pc4=%h ins=%h, want 0 0 %h",
                     id_pc, id_pc_plus4, id_instruction, c_EMPTY_INS);
        end
    endtask

    task automatic test_single();
        id_ready = 1'b1;
        if_valid = 1'b1; if_pc = 32'h0; if_pc_plus4 = 32'h4; if_instruction = 32'h0050_0093;
        tick();
        if_valid = 1'b0;
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h4 ||
            id_instruction !== 32'h0050_0093) begin
            errors++;
            $display("FAIL single_head: valid=%b pc=%h pc4=%h ins=%h, want 1 0 4 00500093",
                     id_valid, id_pc, id_pc_plus4, id_instruction);
        end
        tick();
        checks++;
        if (id_count !== 0 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop: count=%0d valid=%b, want 0 0", id_count, id_valid);
        end
    endtask

    task automatic test_full();
        id_ready = 1'b0;
        present(32'h0); tick();
        present(32'h4); tick();
        present(32'h8); tick();
        checks++;
        if (if_ready !== 1'b0 || id_count !== 2 || id_pc !== 32'h0) begin
            errors++;
            $display("FAIL full_hold: if_ready=%b count=%0d pc=%h, want 0 2 0",
                     if_ready, id_count, id_pc);
        end
        id_ready = 1'b1;
        tick();
        // 0x0 popped; 0x8 could not enter the same cycle
        checks++;
        if (id_pc !== 32'h4 || id_count !== 1 || if_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_second: pc=%h count=%0d if_ready=%b, want 4 1 1",
                     id_pc, id_count, if_ready);
        end
        tick();
        if_valid = 1'b0;
        checks++;
        if (id_pc !== 32'h8 || id_count !== 1 || id_pc_plus4 !== 32'hC) begin
            errors++;
            $display("FAIL full_third: pc=%h pc4=%h count=%0d, want 8 c 1",
                     id_pc, id_pc_plus4, id_count);
        end
        tick();
        checks++;
        if (id_count !== 0) begin
            errors++;
            $display("FAIL full_drain: count=%0d, want 0", id_count);
        end
    endtask

    task automatic test_back_to_back();
        id_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            present(32'(i * 4));
            tick();
            checks++;
            if (id_valid !== 1'b1 || id_count !== 1 || id_pc !== 32'(i * 4) ||
                id_instruction !== (32'(i * 4) ^ 32'h0050_0093)) begin
                errors++;
                $display("FAIL stream_%0d: valid=%b count=%0d pc=%h ins=%h, want 1 1 %h %h",
                         i, id_valid, id_count, id_pc, id_instruction,
                         32'(i * 4), 32'(i * 4) ^ 32'h0050_0093);
            end
        end
        if_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        id_ready = 1'b0;
        present(32'h100); tick();
        present(32'h104); tick();
        checks++;
        if (id_count !== 2) begin
            errors++;
            $display("FAIL flush_fill: count=%0d, want 2", id_count);
        end
        present(32'h40);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (id_valid !== 1'b0 || id_count !== 0 || if_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: valid=%b count=%0d if_ready=%b, want 0 0 1",
                     id_valid, id_count, if_ready);
        end
        tick();
        if_valid = 1'b0;
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_count !== 1) begin
            errors++;
            $display("FAIL flush_repush: valid=%b pc=%h count=%0d, want 1 40 1",
                     id_valid, id_pc, id_count);
        end
        id_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_full();
        id_ready = 1'b0;
        present(32'h300); tick();
        present(32'h304); tick();
        if_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (if_ready !== 1'b1 || id_valid !== 1'b0 || id_count !== 0 || id_pc !== 32'h0 ||
            id_pc_plus4 !== 32'h0 || id_instruction !== c_EMPTY_INS) begin
            errors++;
            $display("FAIL rst_full: rdy=%b v=%b cnt=%0d pc=%h pc4=%h ins=%h, want 1 0 0 0 0 %h",
                     if_ready, id_valid, id_count, id_pc, id_pc_plus4, id_instruction,
                     c_EMPTY_INS);
        end
        present(32'h200);
        tick();
        if_valid = 1'b0;
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_pc_plus4 !== 32'h204 ||
            id_instruction !== (32'h200 ^ 32'h0050_0093)) begin
            errors++;
            $display("FAIL rst_repush: valid=%b pc=%h pc4=%h ins=%h, want 1 200 204 %h",
                     id_valid, id_pc, id_pc_plus4, id_instruction, 32'h200 ^ 32'h0050_0093);
        end
        id_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_flush();
        test_reset_full();
        test_random_traffic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Random traffic obeying the producer hold rule, checked against the queue model
    task automatic test_random_traffic();
        for (int n = 0; n < 600; n++) begin
            if (!(if_valid && !if_ready)) begin
                if_valid       = ($urandom_range(0, 3) != 0);
                if_pc          = $urandom;
                if_pc_plus4    = if_pc + 32'd4;
                if_instruction = $urandom;
            end
            id_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if (id_count !== q.size() || id_valid !== (q.size() != 0) ||
                if_ready !== (q.size() != DEPTH)) begin
                errors++;
                $display("FAIL rand_state_%0d: count=%0d valid=%b rdy=%b, want count %0d",
                         n, id_count, id_valid, if_ready, q.size());
            end
            if (q.size() != 0) begin
                checks++;
                if (id_pc !== q[0].pc || id_pc_plus4 !== q[0].pc4 ||
                    id_instruction !== q[0].ins) begin
                    errors++;
                    $display("FAIL rand_head_%0d: pc=%h pc4=%h ins=%h, want %h %h %h",
                             n, id_pc, id_pc_plus4, id_instruction,
                             q[0].pc, q[0].pc4, q[0].ins);
                end
            end
`ifdef IFID_BUBBLE_NOP_EN
            else begin
                checks++;
                if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h0 || id_instruction !== c_EMPTY_INS) begin
                    errors++;
                    $display("FAIL rand_bubble_%0d: pc=%h pc4=%h ins=%h, want 0 0 %h",
                             n, id_pc, id_pc_plus4, id_instruction, c_EMPTY_INS);
                end
            end
`endif
        end
        flush    = 1'b0;
        if_valid = 1'b0;
    endtask

endmodule

`default_nettype wire
